// File: rtl/rot_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : rot_pkg                                                    |
// | Shared encodings for the rotary-encoder decoder and the              |
// | parameter-edit controller.                                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rot_pkg;

  // Controller modes
  typedef enum logic {
    ST_BROWSE = 1'b0,
    ST_EDIT   = 1'b1
  } state_e;

  // Direction qualifier carried with each detent pulse
  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

endpackage : rot_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : btn_debounce                                               |
// | Synchronizes a raw push-button, debounces it and emits a one-cycle   |
// | pulse on each accepted press (release produces no event).           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;
  logic             press_d;

  // Two-stage synchronizer for the asynchronous button input
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Stability counter: the debounced level follows the synchronized level
  // only after DEB_CYCLES consecutive cycles of disagreement; the update
  // edge itself is the last of those cycles, so a rise is visible as a
  // press on the cycle after 2 + DEB_CYCLES edges.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    press_d = level_d & ~level_q;
  end

  // Debounce state and registered rising-edge pulse
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/rot_param_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rot_param_ctrl                                             |
// | Browse / edit / commit controller for a bank of parameter registers  |
// | driven by rotary-encoder detents and a push-button.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rot_param_ctrl
  import rot_pkg::*;
#(
  parameter int NUM_REGS   = 4,
  parameter int WIDTH      = 8,
  parameter int MAX_VAL    = 255,
  parameter int WRAP       = 0,
  parameter int DEB_CYCLES = 16,
  parameter int TIMEOUT    = 1000,
  localparam int IDXW      = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      rotated,
  input  logic                      dir,
  input  logic                      btn,
  output logic [IDXW-1:0]           sel,
  output logic                      editing,
  output logic [WIDTH-1:0]          shadow,
  output logic [NUM_REGS*WIDTH-1:0] bank,
  output logic                      upd,
  output logic [IDXW-1:0]           upd_idx
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NUM_REGS - 1);

  state_e                           state_q, state_d;
  logic [IDXW-1:0]                  sel_q, sel_d;
  logic [WIDTH-1:0]                 shadow_q, shadow_d;
  logic [NUM_REGS-1:0][WIDTH-1:0]   bank_q, bank_d;
  logic [TW-1:0]                    idle_q, idle_d;
  logic                             upd_q, upd_d;
  logic [IDXW-1:0]                  upd_idx_q, upd_idx_d;

  logic                             deb_level;
  logic                             deb_press;
  logic                             press_ev;

  // One step of the edited value, saturating or wrapping at the bounds
  function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] v,
                                                input logic up);
    logic [WIDTH-1:0] r;
    if (up) begin
      if (v >= MAX_V) r = (WRAP != 0) ? '0 : MAX_V;
      else            r = v + WIDTH'(1);
    end else begin
      if (v == '0)    r = (WRAP != 0) ? MAX_V : '0;
      else            r = v - WIDTH'(1);
    end
    return r;
  endfunction

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .nrst  (nrst),
    .btn   (btn),
    .level (deb_level),
    .press (deb_press)
  );

  // A press pulse always coincides with the newly accepted high level
  assign press_ev = deb_press & deb_level;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_BROWSE;
    else       state_q <= state_d;
  end

  // Next-state, index/value arithmetic, idle timer and commit path.
  // Press outranks rotation; press also outranks a coincident timeout.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    shadow_d  = shadow_q;
    bank_d    = bank_q;
    idle_d    = idle_q;
    upd_d     = 1'b0;
    upd_idx_d = upd_idx_q;
    case (state_q)
      ST_BROWSE: begin
        idle_d = '0;
        if (press_ev) begin
          shadow_d = bank_q[sel_q];
          state_d  = ST_EDIT;
        end else if (rotated) begin
          if (dir == DIR_CW) sel_d = (sel_q == LAST_IDX) ? '0 : sel_q + IDXW'(1);
          else               sel_d = (sel_q == '0) ? LAST_IDX : sel_q - IDXW'(1);
        end
      end
      ST_EDIT: begin
        if (press_ev) begin
          bank_d[sel_q] = shadow_q;
          upd_d         = 1'b1;
          upd_idx_d     = sel_q;
          idle_d        = '0;
          state_d       = ST_BROWSE;
        end else if (rotated) begin
          shadow_d = step_val(shadow_q, dir == DIR_CW);
          idle_d   = '0;
        end else if (idle_q == TW'(TIMEOUT - 1)) begin
          // Abandon the edit: the bank keeps its value, no update pulse
          shadow_d = bank_q[sel_q];
          idle_d   = '0;
          state_d  = ST_BROWSE;
        end else begin
          // Bounded by the timeout branch above, so it never overflows
          idle_d = idle_q + TW'(1);
        end
      end
      default: state_d = ST_BROWSE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sel_q     <= '0;
      shadow_q  <= '0;
      bank_q    <= '0;
      idle_q    <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
    end else begin
      sel_q     <= sel_d;
      shadow_q  <= shadow_d;
      bank_q    <= bank_d;
      idle_q    <= idle_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
    end
  end

  assign sel     = sel_q;
  assign editing = (state_q == ST_EDIT);
  assign shadow  = (state_q == ST_EDIT) ? shadow_q : bank_q[sel_q];
  assign bank    = bank_q;
  assign upd     = upd_q;
  assign upd_idx = upd_idx_q;

endmodule : rot_param_ctrl
`default_nettype wire
